result_mem_writer: RTL



---
 rtl/result_wr_pkg.sv | 23 ++
 rtl/result_bank_tracker.sv | 77 +++++++
 rtl/result_mem_writer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/result_wr_pkg.sv
// Shared types and helpers for the result memory writer.
// Holds the writer/bank state enums and the byte-lane decode.
package result_wr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DROP
    } wr_state_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        READY
    } bank_state_t;

    localparam int FRAME_BYTES_DEF = 12288;

    function automatic logic [3:0] lane_decode(input logic [1:0] lane);
        lane_decode = 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/result_bank_tracker.sv
// Double-buffer bank bookkeeping: allocation, completion, host release
// and the oldest-ready pointer shown to the host.
module result_bank_tracker
    import result_wr_pkg::*;
(
    input  logic clk_result,
    input  logic reset_n,
    input  logic alloc,
    input  logic complete,
    input  logic complete_bank,
    input  logic host_release,
    output logic alloc_ok,
    output logic alloc_bank,
    output logic result_ready,
    output logic result_bank
);

    bank_state_t st   [2];
    bank_state_t st_n [2];
    logic        last_filled;
    logic        oldest;
    logic        oldest_n;
    logic        other_fill;
    logic        other_old;
    logic        rel;
    logic [1:0]  avail;

    assign result_ready = (st[0] == READY) || (st[1] == READY);
    assign result_bank  = oldest;
    assign other_fill   = ~last_filled;
    assign other_old    = ~oldest;

    always_comb begin
        rel        = host_release && result_ready;
        avail      = '0;
        alloc_ok   = 1'b0;
        alloc_bank = last_filled;
        oldest_n   = oldest;
        st_n[0]    = st[0];
        st_n[1]    = st[1];

        // A bank freed this cycle may be handed straight to a new frame.
        for (int b = 0; b < 2; b++) begin
            avail[b] = (st[b] == EMPTY) || (rel && (oldest == 1'(b)));
        end
        alloc_ok   = |avail;
        alloc_bank = avail[other_fill] ? other_fill : last_filled;

        for (int b = 0; b < 2; b++) begin
            if (rel && (oldest == 1'(b)))
                st_n[b] = EMPTY;
            if (alloc && (alloc_bank == 1'(b)))
                st_n[b] = FILL;
            if (complete && (complete_bank == 1'(b)))
                st_n[b] = READY;
        end

        if (st_n[oldest] != READY && st_n[other_old] == READY)
            oldest_n = other_old;
    end

    always_ff @(posedge clk_result) begin
        if (!reset_n) begin
            st[0]       <= EMPTY;
            st[1]       <= EMPTY;
            last_filled <= 1'b1;
            oldest      <= 1'b0;
        end else begin
            st[0]  <= st_n[0];
            st[1]  <= st_n[1];
            oldest <= oldest_n;
            if (alloc)
                last_filled <= alloc_bank;
        end
    end

endmodule

// File: rtl/result_mem_writer.sv
// Writes the DSP result byte stream into a double-buffered frame store
// over a byte-laned 32-bit memory port, dropping frames with no free bank.
module result_mem_writer
    import result_wr_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int CNT_W       = 16
) (
    input  logic              clk_result,
    input  logic              reset_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_sof,
    input  logic              s_eof,
    input  logic              s_sop,
    input  logic              s_eop,
    input  logic              enable,
    input  logic              host_release,
    input  logic              clear_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable,
    output logic              result_ready,
    output logic              result_bank,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              len_error
);

    localparam int OFF_W = $clog2(FRAME_BYTES + 1);
    localparam logic [OFF_W-1:0] FB      = OFF_W'(FRAME_BYTES);
    localparam logic [OFF_W-1:0] FB_LAST = OFF_W'(FRAME_BYTES - 1);

    wr_state_t         state, state_n;
    logic [OFF_W-1:0]  offset, off_n;
    logic [OFF_W-1:0]  wr_off;
    logic [ADDR_W-2:0] word;
    logic              fill_bank, bank_n, wr_bank;
    logic              wr, wr_q;
    logic              alloc, alloc_ok, alloc_bank;
    logic              complete, cbank;
    logic              frame_inc, drop_inc, err_set;
    logic              unused_markers;

    assign unused_markers = s_sop ^ s_eop;

    assign mem_write      = wr_q;
    assign mem_chipselect = wr_q;
    assign mem_clken      = wr_q;

    result_bank_tracker u_tracker (
        .clk_result    (clk_result),
        .reset_n       (reset_n),
        .alloc         (alloc),
        .complete      (complete),
        .complete_bank (cbank),
        .host_release  (host_release),
        .alloc_ok      (alloc_ok),
        .alloc_bank    (alloc_bank),
        .result_ready  (result_ready),
        .result_bank   (result_bank)
    );

    always_comb begin
        state_n   = state;
        off_n     = offset;
        bank_n    = fill_bank;
        wr        = 1'b0;
        wr_off    = '0;
        wr_bank   = fill_bank;
        alloc     = 1'b0;
        complete  = 1'b0;
        cbank     = fill_bank;
        frame_inc = 1'b0;
        drop_inc  = 1'b0;
        err_set   = 1'b0;

        unique case (state)
            IDLE: begin
                if (s_valid && s_sof) begin
                    if (enable && alloc_ok) begin
                        alloc   = 1'b1;
                        wr      = 1'b1;
                        wr_bank = alloc_bank;
                        bank_n  = alloc_bank;
                        off_n   = OFF_W'(1);
                        if (s_eof) begin
                            complete  = 1'b1;
                            cbank     = alloc_bank;
                            frame_inc = 1'b1;
                            if (FB_LAST != '0)
                                err_set = 1'b1;
                        end else begin
                            state_n = WRITE;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        if (!s_eof)
                            state_n = DROP;
                    end
                end
            end
            WRITE: begin
                if (s_valid) begin
                    if (s_sof) begin
                        // Restart in place; the aborted frame is lost.
                        err_set = 1'b1;
                        wr      = 1'b1;
                        off_n   = OFF_W'(1);
                    end else if (offset == FB) begin
                        err_set = 1'b1;
                    end else begin
                        wr     = 1'b1;
                        wr_off = offset;
                        off_n  = offset + 1'b1;
                    end
                    if (s_eof) begin
                        complete  = 1'b1;
                        frame_inc = 1'b1;
                        state_n   = IDLE;
                        if (s_sof || offset != FB_LAST)
                            err_set = 1'b1;
                    end
                end
            end
            DROP: begin
                if (s_valid && s_eof)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign word = (ADDR_W-1)'(wr_off >> 2);

    always_ff @(posedge clk_result) begin
        if (!reset_n) begin
            state          <= IDLE;
            offset         <= '0;
            fill_bank      <= 1'b0;
            wr_q           <= 1'b0;
            mem_address    <= '0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
            frame_count    <= '0;
            drop_count     <= '0;
            len_error      <= 1'b0;
        end else begin
            state     <= state_n;
            offset    <= off_n;
            fill_bank <= bank_n;
            wr_q      <= wr;
            mem_byteenable <= wr ? lane_decode(wr_off[1:0]) : 4'b0000;
            if (wr) begin
                mem_address   <= {wr_bank, word};
                mem_writedata <= {4{s_data}};
            end
            if (frame_inc)
                frame_count <= frame_count + 1'b1;
            if (drop_inc)
                drop_count <= drop_count + 1'b1;
            if (err_set)
                len_error <= 1'b1;
            else if (clear_err)
                len_error <= 1'b0;
        end
    end

endmodule
